// File: rtl/sprite_pkg.sv
// Shared types and constants for the Dino-Jump sprite compositor: fixed layer
// colours, the blink state type and the "DED" death-screen glyph rectangles.
package sprite_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

    // Half-open bounds: x0 <= x < x1, y0 <= y < y1
    typedef struct packed {
        int unsigned x0;
        int unsigned x1;
        int unsigned y0;
        int unsigned y1;
    } rect_t;

    typedef enum logic {BlinkOn, BlinkOff} blink_state_e;

    localparam rgb4_t FLOOR_COLOR = '{r: 4'hF, g: 4'hA, b: 4'h0};
    localparam rgb4_t DEATH_COLOR = '{r: 4'hF, g: 4'h0, b: 4'h0};

    localparam int NUM_GLYPH_RECTS = 14;

    // Two Ds (left stem, top, bottom, corner bevel, right stem) around an E
    localparam rect_t GLYPH_RECTS [NUM_GLYPH_RECTS] = '{
        '{170, 190,  80, 180}, '{190, 240,  80, 100}, '{190, 240, 160, 180},
        '{240, 250,  90, 170}, '{245, 260, 100, 160},
        '{285, 305,  80, 180}, '{305, 375,  80, 100}, '{305, 360, 120, 140},
        '{305, 375, 160, 180},
        '{400, 420,  80, 180}, '{420, 470,  80, 100}, '{420, 470, 160, 180},
        '{470, 480,  90, 170}, '{475, 490, 100, 160}
    };

    function automatic logic in_glyph(input int unsigned x, input int unsigned y);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_GLYPH_RECTS; i++) begin
            hit = hit | ((x >= GLYPH_RECTS[i].x0) && (x < GLYPH_RECTS[i].x1) &&
                         (y >= GLYPH_RECTS[i].y0) && (y < GLYPH_RECTS[i].y1));
        end
        return hit;
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel/sprite-attribute bundle between game logic (master) and the
// compositor (slave), plus the composited colour returned to the VGA path.
interface sprite_compositor_if #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned COORD_W     = 12,
    parameter int unsigned PIX_W       = 10,
    parameter int unsigned COLOR_W     = 4
);
    logic                             frame_start;
    logic                             pix_valid;
    logic [PIX_W-1:0]                 pix_x;
    logic [PIX_W-1:0]                 pix_y;
    logic                             game_over;
    logic [NUM_SPRITES-1:0]           spr_en;
    logic [NUM_SPRITES-1:0]           spr_stripe;
    logic [NUM_SPRITES*COORD_W-1:0]   spr_x;
    logic [NUM_SPRITES*COORD_W-1:0]   spr_y;
    logic [NUM_SPRITES*COORD_W-1:0]   spr_w;
    logic [NUM_SPRITES*COORD_W-1:0]   spr_h;
    logic [NUM_SPRITES*3*COLOR_W-1:0] spr_color;
    logic                             out_valid;
    logic [COLOR_W-1:0]               red;
    logic [COLOR_W-1:0]               green;
    logic [COLOR_W-1:0]               blue;

    modport master (
        output frame_start, pix_valid, pix_x, pix_y, game_over,
        output spr_en, spr_stripe, spr_x, spr_y, spr_w, spr_h, spr_color,
        input  out_valid, red, green, blue
    );

    modport slave (
        input  frame_start, pix_valid, pix_x, pix_y, game_over,
        input  spr_en, spr_stripe, spr_x, spr_y, spr_w, spr_h, spr_color,
        output out_valid, red, green, blue
    );
endinterface

// File: rtl/sprite_hit.sv
// Combinational hit and stripe-black test of one pixel against one sprite slot.
module sprite_hit #(
    parameter int unsigned COORD_W      = 12,
    parameter int unsigned PIX_W        = 10,
    parameter int unsigned STRIPE_INSET = 3
) (
    input  logic               i_en,
    input  logic               i_stripe,
    input  logic [COORD_W-1:0] i_sx,
    input  logic [COORD_W-1:0] i_sy,
    input  logic [COORD_W-1:0] i_w,
    input  logic [COORD_W-1:0] i_h,
    input  logic [PIX_W-1:0]   i_x,
    input  logic [PIX_W-1:0]   i_y,
    output logic               o_hit,
    output logic               o_black
);
    localparam int unsigned SW = COORD_W + 1;

    logic [SW-1:0] w_x, w_y, w_sx, w_sy, w_x_end, w_y_end, w_dx;
    logic          w_near_left, w_near_right;

    // One extra bit keeps sx+w and sy+h from wrapping
    assign w_x     = SW'(i_x);
    assign w_y     = SW'(i_y);
    assign w_sx    = SW'(i_sx);
    assign w_sy    = SW'(i_sy);
    assign w_x_end = w_sx + SW'(i_w);
    assign w_y_end = w_sy + SW'(i_h);
    assign w_dx    = w_x - w_sx;

    assign o_hit = i_en && (w_x >= w_sx) && (w_x < w_x_end) && (w_y >= w_sy) && (w_y < w_y_end);

    // dx >= w - inset rewritten as dx + inset >= w so a narrow sprite never underflows
    assign w_near_left  = w_dx < SW'(STRIPE_INSET);
    assign w_near_right = ({1'b0, w_dx} + (SW + 1)'(STRIPE_INSET)) >= (SW + 1)'(i_w);

    assign o_black = o_hit && i_stripe && !i_y[0] && (w_near_left || w_near_right);
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: overlay > floor > sprites > background, with sprite
// attributes shadowed at frame start and a blinking death-screen overlay.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES  = 4,
    parameter int unsigned COORD_W      = 12,
    parameter int unsigned PIX_W        = 10,
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned FLOOR_Y      = 460,
    parameter int unsigned STRIPE_INSET = 3,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input logic                clk,
    input logic                reset,
    sprite_compositor_if.slave bus
);
    localparam int unsigned RGB_W = 3 * COLOR_W;
    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RGB_W-1:0] FLOOR_RGB =
        {COLOR_W'(FLOOR_COLOR.r), COLOR_W'(FLOOR_COLOR.g), COLOR_W'(FLOOR_COLOR.b)};
    localparam logic [RGB_W-1:0] DEATH_RGB =
        {COLOR_W'(DEATH_COLOR.r), COLOR_W'(DEATH_COLOR.g), COLOR_W'(DEATH_COLOR.b)};

    logic [NUM_SPRITES-1:0]         r_spr_en, r_spr_stripe;
    logic [NUM_SPRITES*COORD_W-1:0] r_spr_x, r_spr_y, r_spr_w, r_spr_h;
    logic [NUM_SPRITES*RGB_W-1:0]   r_spr_color;
    logic                           r_game_over;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spr_en     <= '0;
            r_spr_stripe <= '0;
            r_spr_x      <= '0;
            r_spr_y      <= '0;
            r_spr_w      <= '0;
            r_spr_h      <= '0;
            r_spr_color  <= '0;
            r_game_over  <= 1'b0;
        end else if (bus.frame_start) begin
            r_spr_en     <= bus.spr_en;
            r_spr_stripe <= bus.spr_stripe;
            r_spr_x      <= bus.spr_x;
            r_spr_y      <= bus.spr_y;
            r_spr_w      <= bus.spr_w;
            r_spr_h      <= bus.spr_h;
            r_spr_color  <= bus.spr_color;
            r_game_over  <= bus.game_over;
        end
    end

    blink_state_e     r_blink, w_blink_next;
    logic [CNT_W-1:0] r_blink_cnt, w_blink_cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink     <= BlinkOn;
            r_blink_cnt <= '0;
        end else begin
            r_blink     <= w_blink_next;
            r_blink_cnt <= w_blink_cnt_next;
        end
    end

    always_comb begin
        w_blink_next     = r_blink;
        w_blink_cnt_next = r_blink_cnt;
        if (bus.frame_start) begin
            // The frame that first latches game_over starts a fresh ON phase
            if (!bus.game_over || !r_game_over) begin
                w_blink_next     = BlinkOn;
                w_blink_cnt_next = '0;
            end else if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                w_blink_next     = (r_blink == BlinkOn) ? BlinkOff : BlinkOn;
                w_blink_cnt_next = '0;
            end else begin
                w_blink_cnt_next = r_blink_cnt + CNT_W'(1);
            end
        end else if (!r_game_over) begin
            w_blink_next     = BlinkOn;
            w_blink_cnt_next = '0;
        end
    end

    logic [NUM_SPRITES-1:0] w_hit, w_black;
    logic [RGB_W-1:0]       w_spr_rgb;
    logic                   w_floor, w_overlay;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
        sprite_hit #(
            .COORD_W      (COORD_W),
            .PIX_W        (PIX_W),
            .STRIPE_INSET (STRIPE_INSET)
        ) u_hit (
            .i_en     (r_spr_en[i]),
            .i_stripe (r_spr_stripe[i]),
            .i_sx     (r_spr_x[i*COORD_W +: COORD_W]),
            .i_sy     (r_spr_y[i*COORD_W +: COORD_W]),
            .i_w      (r_spr_w[i*COORD_W +: COORD_W]),
            .i_h      (r_spr_h[i*COORD_W +: COORD_W]),
            .i_x      (bus.pix_x),
            .i_y      (bus.pix_y),
            .o_hit    (w_hit[i]),
            .o_black  (w_black[i])
        );
    end

    // Walk from lowest to highest priority so the lowest-index hit wins
    always_comb begin
        w_spr_rgb = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) w_spr_rgb = w_black[i] ? '0 : r_spr_color[i*RGB_W +: RGB_W];
        end
    end

    assign w_floor   = 32'(bus.pix_y) >= FLOOR_Y;
    assign w_overlay = r_game_over && (r_blink == BlinkOn) &&
                       in_glyph(32'(bus.pix_x), 32'(bus.pix_y));

    // Selected sprite colour is captured here so a same-cycle frame_start cannot
    // swap the palette under a pixel already in flight
    logic                   r_s1_valid, r_s1_floor, r_s1_overlay;
    logic [NUM_SPRITES-1:0] r_s1_hit;
    logic [RGB_W-1:0]       r_s1_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_floor   <= 1'b0;
            r_s1_overlay <= 1'b0;
            r_s1_hit     <= '0;
            r_s1_rgb     <= '0;
        end else begin
            r_s1_valid   <= bus.pix_valid;
            r_s1_floor   <= w_floor;
            r_s1_overlay <= w_overlay;
            r_s1_hit     <= w_hit;
            r_s1_rgb     <= w_spr_rgb;
        end
    end

    logic [RGB_W-1:0] w_out_rgb, r_out_rgb;
    logic             r_out_valid;

    always_comb begin
        w_out_rgb = '0;
        if (r_s1_valid) begin
            if (r_s1_overlay)   w_out_rgb = DEATH_RGB;
            else if (r_s1_floor) w_out_rgb = FLOOR_RGB;
            else if (|r_s1_hit)  w_out_rgb = r_s1_rgb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_rgb   <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_rgb   <= w_out_rgb;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.red       = r_out_rgb[RGB_W-1 -: COLOR_W];
    assign bus.green     = r_out_rgb[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue      = r_out_rgb[COLOR_W-1:0];
endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: table vectors, hand sequences for blink, shadow
// timing and reset, then random pixels against a frame-level reference model.
module tb_sprite_compositor;
    localparam int NS = 4;
    localparam int CW = 12;
    localparam int PW = 10;
    localparam int CLW = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_compositor_if #(.NUM_SPRITES(NS), .COORD_W(CW), .PIX_W(PW), .COLOR_W(CLW)) bus ();

    sprite_compositor #(
        .NUM_SPRITES  (NS),
        .COORD_W      (CW),
        .PIX_W        (PW),
        .COLOR_W      (CLW),
        .FLOOR_Y      (460),
        .STRIPE_INSET (3),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Values presented on the bus
    int          t_sx[NS], t_sy[NS], t_w[NS], t_h[NS];
    logic [11:0] t_col[NS];
    logic [NS-1:0] t_en, t_stripe;
    logic        t_go;

    // Reference model: what the DUT should have latched, and frames since death
    int          m_sx[NS], m_sy[NS], m_w[NS], m_h[NS];
    logic [11:0] m_col[NS];
    logic [NS-1:0] m_en, m_stripe;
    logic        m_go;
    int          m_k;

    logic        e_v[2];
    logic [11:0] e_rgb[2];
    string       e_name[2];

    int checks, errors;

    typedef struct {
        logic [3:0]  en;
        int          x;
        int          y;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: {valid,rgb} got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic glyph(input int x, input int y);
        int dx;
        if (y < 80 || y >= 180) return 1'b0;
        // letter D at two origins
        for (int k = 0; k < 2; k++) begin
            dx = x - (k == 0 ? 170 : 400);
            if (dx >= 0 && dx < 20) return 1'b1;
            if (dx >= 20 && dx < 70 && (y < 100 || y >= 160)) return 1'b1;
            if (dx >= 70 && dx < 80 && y >= 90 && y < 170) return 1'b1;
            if (dx >= 75 && dx < 90 && y >= 100 && y < 160) return 1'b1;
        end
        dx = x - 285;
        if (dx >= 0 && dx < 20) return 1'b1;
        if (dx >= 20 && dx < 90 && (y < 100 || y >= 160)) return 1'b1;
        if (dx >= 20 && dx < 75 && y >= 120 && y < 140) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [11:0] ref_rgb(input int x, input int y);
        int dx;
        if (m_go && ((m_k / BF) % 2 == 0) && glyph(x, y)) return 12'hF00;
        if (y >= 460) return 12'hFA0;
        for (int i = 0; i < NS; i++) begin
            if (m_en[i] && x >= m_sx[i] && x < m_sx[i] + m_w[i] &&
                y >= m_sy[i] && y < m_sy[i] + m_h[i]) begin
                dx = x - m_sx[i];
                if (m_stripe[i] && (y % 2 == 0) && (dx < 3 || dx >= m_w[i] - 3)) return 12'h000;
                return m_col[i];
            end
        end
        return 12'h000;
    endfunction

    task automatic model_clear();
        m_en = '0; m_stripe = '0; m_go = 1'b0; m_k = 0;
        for (int i = 0; i < NS; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_w[i] = 0; m_h[i] = 0; m_col[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            e_v[i] = 1'b0; e_rgb[i] = '0; e_name[i] = "idle";
        end
    endtask

    task automatic drive(input logic fs, input logic pv, input int x, input int y);
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        bus.pix_x       = PW'(x);
        bus.pix_y       = PW'(y);
        bus.game_over   = t_go;
        bus.spr_en      = t_en;
        bus.spr_stripe  = t_stripe;
        for (int i = 0; i < NS; i++) begin
            bus.spr_x[i*CW +: CW]       = CW'(t_sx[i]);
            bus.spr_y[i*CW +: CW]       = CW'(t_sy[i]);
            bus.spr_w[i*CW +: CW]       = CW'(t_w[i]);
            bus.spr_h[i*CW +: CW]       = CW'(t_h[i]);
            bus.spr_color[i*12 +: 12]   = t_col[i];
        end
    endtask

    // One pixel clock: check the pixel issued two cycles ago, then issue a new one
    task automatic step(input logic fs, input logic pv, input int x, input int y,
                        input logic [11:0] exp_rgb, input string name);
        @(negedge clk);
        check(e_name[1], {bus.out_valid, bus.red, bus.green, bus.blue},
              {e_v[1], e_v[1] ? e_rgb[1] : 12'h000});
        e_v[1] = e_v[0]; e_rgb[1] = e_rgb[0]; e_name[1] = e_name[0];
        e_v[0] = pv; e_rgb[0] = pv ? exp_rgb : 12'h000; e_name[0] = name;
        drive(fs, pv, x, y);
        if (fs) begin
            if (t_go && m_go) m_k++;
            else m_k = 0;
            m_go = t_go;
            m_en = t_en; m_stripe = t_stripe;
            for (int i = 0; i < NS; i++) begin
                m_sx[i] = t_sx[i]; m_sy[i] = t_sy[i]; m_w[i] = t_w[i]; m_h[i] = t_h[i];
                m_col[i] = t_col[i];
            end
        end
    endtask

    task automatic reset_mid();
        #2 reset = 1'b1;
        #1;
        check("reset_mid_outputs", {bus.out_valid, bus.red, bus.green, bus.blue}, 13'h0);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic fs, pv;
        int   x, y;
        checks = 0; errors = 0;
        t_en = '0; t_stripe = '0; t_go = 1'b0;
        for (int i = 0; i < NS; i++) begin
            t_sx[i] = 0; t_sy[i] = 0; t_w[i] = 0; t_h[i] = 0; t_col[i] = '0;
        end
        model_clear();
        drive(1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("reset_state", {bus.out_valid, bus.red, bus.green, bus.blue}, 13'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fixed scene for the table
        t_sx[0] = 20;  t_sy[0] = 430; t_w[0] = 30;  t_h[0] = 30; t_col[0] = 12'h0F0;
        t_sx[1] = 30;  t_sy[1] = 440; t_w[1] = 30;  t_h[1] = 30; t_col[1] = 12'h040;
        t_sx[2] = 100; t_sy[2] = 400; t_w[2] = 15;  t_h[2] = 59; t_col[2] = 12'h88C;
        t_sx[3] = 0;   t_sy[3] = 400; t_w[3] = 120; t_h[3] = 80; t_col[3] = 12'h00F;
        t_stripe = 4'b0100;

        vecs.push_back('{4'hF,  35, 445, 12'h0F0});
        vecs.push_back('{4'hE,  35, 445, 12'h040});
        vecs.push_back('{4'h8,  35, 445, 12'h00F});
        vecs.push_back('{4'h0,  35, 445, 12'h000});
        vecs.push_back('{4'hF, 101, 402, 12'h000});
        vecs.push_back('{4'hF, 101, 403, 12'h88C});
        vecs.push_back('{4'hF, 106, 402, 12'h88C});
        vecs.push_back('{4'hF, 111, 402, 12'h88C});
        vecs.push_back('{4'hF, 112, 402, 12'h000});
        vecs.push_back('{4'hF, 115, 402, 12'h00F});
        vecs.push_back('{4'hF,  99, 402, 12'h00F});
        vecs.push_back('{4'hF, 103, 457, 12'h88C});
        vecs.push_back('{4'hF,  10, 465, 12'hFA0});
        vecs.push_back('{4'hF,  10, 459, 12'h00F});
        vecs.push_back('{4'hF,  50, 459, 12'h040});
        vecs.push_back('{4'hF,  49, 460, 12'hFA0});

        foreach (vecs[r]) begin
            t_en = vecs[r].en;
            step(1'b1, 1'b0, 0, 0, 12'h000, "table_latch");
            step(1'b0, 1'b1, vecs[r].x, vecs[r].y, vecs[r].exp, $sformatf("table[%0d]", r));
        end

        // Blink: 2 frames on, 2 frames off
        t_en = '0;
        t_go = 1'b1;
        for (int f = 0; f < 8; f++) begin
            step(1'b1, 1'b0, 0, 0, 12'h000, "blink_latch");
            step(1'b0, 1'b1, 175, 100, ((f / 2) % 2 == 0) ? 12'hF00 : 12'h000,
                 $sformatf("blink_glyph_f%0d", f));
            step(1'b0, 1'b1, 300, 130, ((f / 2) % 2 == 0) ? 12'hF00 : 12'h000,
                 $sformatf("blink_e_f%0d", f));
            step(1'b0, 1'b1, 260, 100, 12'h000, $sformatf("blink_gap_f%0d", f));
        end
        t_go = 1'b0;
        step(1'b1, 1'b0, 0, 0, 12'h000, "blink_clear");
        step(1'b0, 1'b1, 175, 100, 12'h000, "blink_cleared");
        t_go = 1'b1;
        step(1'b1, 1'b0, 0, 0, 12'h000, "blink_relatch");
        step(1'b0, 1'b1, 175, 100, 12'hF00, "blink_restart_on");
        t_go = 1'b0;
        step(1'b1, 1'b0, 0, 0, 12'h000, "blink_clear2");

        // Shadow timing
        t_en = 4'b0001; t_stripe = '0;
        t_sx[0] = 200; t_sy[0] = 300; t_w[0] = 10; t_h[0] = 10; t_col[0] = 12'h0F0;
        step(1'b1, 1'b0, 0, 0, 12'h000, "shadow_latch");
        step(1'b0, 1'b1, 205, 305, 12'h0F0, "shadow_base");
        t_sx[0] = 300;
        step(1'b0, 1'b1, 205, 305, 12'h0F0, "shadow_hold");
        step(1'b1, 1'b1, 205, 305, 12'h0F0, "shadow_same_cycle_old_x");
        step(1'b0, 1'b1, 205, 305, 12'h000, "shadow_next_new_x_miss");
        step(1'b0, 1'b1, 305, 305, 12'h0F0, "shadow_next_new_x_hit");

        // Reset in the middle of a valid stream
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10, 470, 12'hFA0, "pre_reset");
        reset_mid();
        step(1'b0, 1'b1, 10, 470, 12'hFA0, "post_reset_first");
        step(1'b0, 1'b0, 0, 0, 12'h000, "post_reset_gap");
        step(1'b0, 1'b1, 305, 305, 12'h000, "post_reset_shadow_clear");
        step(1'b0, 1'b0, 0, 0, 12'h000, "post_reset_idle");

        // Random scenes and pixels against the model
        t_go = 1'b1;
        for (int it = 0; it < 2000; it++) begin
            if (it % 50 == 0) begin
                for (int i = 0; i < NS; i++) begin
                    t_en[i]     = 1'($urandom_range(0, 3) != 0);
                    t_stripe[i] = 1'($urandom_range(0, 1));
                    t_sx[i]     = $urandom_range(0, 500);
                    t_sy[i]     = $urandom_range(0, 470);
                    t_w[i]      = $urandom_range(0, 120);
                    t_h[i]      = $urandom_range(0, 120);
                    t_col[i]    = 12'($urandom);
                end
                if (it % 100 == 0) begin
                    t_sx[3] = 50; t_w[3] = 4080; t_en[3] = 1'b1;
                end
            end
            if ($urandom_range(0, 199) == 0) t_go = ~t_go;
            fs = 1'($urandom_range(0, 15) == 0);
            pv = 1'($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                x = $urandom_range(160, 500);
                y = $urandom_range(70, 190);
            end else begin
                x = $urandom_range(0, 639);
                y = $urandom_range(0, 479);
            end
            step(fs, pv, x, y, ref_rgb(x, y), "random");
        end

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 12'h000, "flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Pipelined, parametrised pixel compositor for the Dino-Jump VGA path. It sits between the game-logic block and the VGA sync/DAC output. Each cycle it takes one pixel coordinate and returns the RGB for that pixel from these layers: a death-screen text overlay, the floor band, N priority-ordered rectangular sprites, and the background. Sprite attributes are double-buffered at frame start so the picture never tears, and the overlay blinks at a parametrised frame rate.

## Interface
- NUM_SPRITES, 4: number of sprite slots; index 0 has the highest priority.
- COORD_W, 12: width of sprite coordinates and sizes.
- PIX_W, 10: width of pixel coordinates.
- COLOR_W, 4: bits per colour channel.
- FLOOR_Y, 460: first row of the floor band.
- STRIPE_INSET, 3: column inset for the striped (cactus) sprite mode.
- BLINK_FRAMES, 30: frames per overlay blink half-period; must be ≥1.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pix_valid  in  1  pix_x/pix_y carry a visible pixel.
- pix_x, pix_y  in  PIX_W each  pixel coordinate.
- game_over  in  1  death state from game logic.
- spr_en  in  NUM_SPRITES  per-slot enable.
- spr_stripe  in  NUM_SPRITES  per-slot striped mode.
- spr_x, spr_y, spr_w, spr_h  in  NUM_SPRITES*COORD_W each  top-left corner and size, packed with slot i at [i*COORD_W +: COORD_W].
- spr_color  in  NUM_SPRITES*3*COLOR_W  per-slot {R,G,B}.
- out_valid  out  1  red/green/blue are valid.
- red, green, blue  out  COLOR_W each  composited colour.

## Operation
Shadow registers:
- On frame_start, latch every spr_* input and game_over into shadow registers.
- Compositing uses only the shadow values.
- After reset, all shadows are 0, so every sprite is disabled and game_over is clear.

Sprite hit test:
- A pixel hits slot i when shadow enable is set, sx ≤ x < sx+w, and sy ≤ y < sy+h.
- Sums are computed at COORD_W+1 bits, so they never wrap.
- A slot with w=0 or h=0 never hits.
- pix_x/pix_y are zero-extended to COORD_W+1 before comparison.

Striped mode:
- A hit pixel is forced to black when y is even and either (x−sx) < STRIPE_INSET or (x−sx) ≥ w−STRIPE_INSET.
- A stripe-black pixel still counts as a hit, so it masks lower-priority slots.

Layer priority, highest first:
1. Overlay: shadow game_over AND blink_on AND the pixel lies inside any GLYPH_RECTS rectangle. Output is DEATH_COLOR.
2. Floor: y ≥ FLOOR_Y. Output is FLOOR_COLOR.
3. Sprite: the lowest-index hit slot, using its colour or stripe black.
4. Background: black.

Blink state machine, two states ON and OFF, with a frame counter:
- While shadow game_over = 0: state is ON and the counter is 0.
- While shadow game_over = 1: each frame_start increments the counter.
- When the counter reaches BLINK_FRAMES−1, the counter wraps to 0 and the state toggles.
- Reset puts the machine in ON with the counter at 0.

## Timing
- Stage 1 registers: per-slot hit, per-slot stripe-black, floor hit, overlay hit, and the valid bit.
- Stage 2 registers: the priority-muxed RGB.
- Latency is 2 cycles: out_valid(t+2) = pix_valid(t). The block accepts one pixel every cycle and never stalls.
- When pix_valid = 0, out_valid is 0 two cycles later and the RGB output is 0.
- frame_start and pix_valid in the same cycle: that pixel uses the old shadow values. The new values apply from the next cycle.
- The blink state updates on the same frame_start edge that latches game_over, using the newly latched value.
- Reset is allowed at any time. It asynchronously clears both pipeline stages, all shadows, and the blink machine. out_valid, red, green, blue and the internal blink state all read 0/ON immediately, and pixels in flight are dropped.

## Structure
- Package sprite_pkg holds: FLOOR_COLOR = {F,A,0}; DEATH_COLOR = {F,0,0}; a rectangle typedef {x0,x1,y0,y1} with half-open bounds; and GLYPH_RECTS, the 14 rectangles spelling "DED" inside the box x∈[170,490), y∈[80,180).
- One sub-module, sprite_hit, instantiated NUM_SPRITES times. It is combinational hit and stripe logic for one slot, feeding the stage-1 registers.

## Test plan
- Reset asserted mid-stream with pix_valid=1 → out_valid, red, green and blue read 0 at once. After release, the first valid output appears exactly 2 cycles after pix_valid.
- Slot 0 at (20,430) with w=30, h=30 and colour {0,F,0}; slot 1 at (30,440) with colour {0,4,0}; pixel (35,445) → {0,F,0}. With slot 0 disabled, the same pixel gives {0,4,0}.
- Striped slot at (100,400), w=15, h=59. Pixel (101,402) → black. Pixel (101,403) → sprite colour. Pixel (106,402) → sprite colour.
- Pixel (10,465) with a sprite covering it → {F,A,0}. Pixel (10,459) → the sprite colour.
- game_over=1 latched at a frame_start, BLINK_FRAMES=2, pixel (175,100): output is {F,0,0} for 2 frames, then black for 2 frames, repeating. Pixel (260,100) stays black throughout.
- Sprite x changed with no frame_start → output unchanged. With frame_start pulsed in the same cycle as a pixel, that pixel uses the old x and the next pixel uses the new x.
